// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream bundle used by axis_frame_gen.
// Signals: tvalid, tready, tdata, tstrb, tlast.
// master drives valid/data/strb/last and samples ready; slave is the mirror.
// The instantiating module must set DATA_WIDTH to the generator's
// C_M00_AXIS_TDATA_WIDTH.
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI4-Stream master producing framed incrementing-count traffic.
// Ports:
//   aclk, areset      clock, synchronous active-high reset
//   i_start           run request (only looked at in IDLE)
//   i_stop            graceful stop, honoured at the next frame boundary
//   i_frame_len       words per frame
//   i_num_frames      frames per run
//   i_gap_cycles      idle cycles between frames
//   i_start_value     tdata of the first word of a run
//   o_busy            run in progress
//   o_done            one-cycle pulse at end of run
//   o_frames_sent     frames fully accepted in the current/last run
//   m00_axis          stream master port (all outputs registered)
//
// state  | meaning
// IDLE   | waiting for start
// SEND   | presenting beats of the current frame
// GAP    | tvalid low between frames
// FINISH | one-cycle done pulse, then back to IDLE
module axis_frame_gen #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_LEN_WIDTH        = 16,
  parameter int GAP_WIDTH              = 8
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              i_start,
  input  logic                              i_stop,
  input  logic [FRAME_LEN_WIDTH-1:0]        i_frame_len,
  input  logic [15:0]                       i_num_frames,
  input  logic [GAP_WIDTH-1:0]              i_gap_cycles,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] i_start_value,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [15:0]                       o_frames_sent,
  axis_frame_gen_if.master                  m00_axis
);

  localparam int DW = C_M00_AXIS_TDATA_WIDTH;
  localparam int LW = FRAME_LEN_WIDTH;
  localparam int GW = GAP_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FINISH} state_t;

  state_t          r_state,   w_state_nxt;
  logic [LW-1:0]   r_len,     w_len_nxt;
  logic [15:0]     r_num,     w_num_nxt;
  logic [GW-1:0]   r_gap,     w_gap_nxt;
  logic [GW-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic [LW-1:0]   r_beat,    w_beat_nxt;
  logic [DW-1:0]   r_tdata,   w_tdata_nxt;
  logic            r_tvalid,  w_tvalid_nxt;
  logic            r_tlast,   w_tlast_nxt;
  logic            r_busy,    w_busy_nxt;
  logic            r_done,    w_done_nxt;
  logic [15:0]     r_frames,  w_frames_nxt;
  logic            r_stop,    w_stop_nxt;

  logic            w_accept;
  logic [LW-1:0]   w_len_m1;

  assign w_accept = r_tvalid & m00_axis.tready;
  assign w_len_m1 = r_len - LW'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_num_nxt     = r_num;
    w_gap_nxt     = r_gap;
    w_gap_cnt_nxt = r_gap_cnt;
    w_beat_nxt    = r_beat;
    w_tdata_nxt   = r_tdata;
    w_tvalid_nxt  = r_tvalid;
    w_tlast_nxt   = r_tlast;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_frames_nxt  = r_frames;
    w_stop_nxt    = r_stop;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_frames_nxt = '0;
          if (i_frame_len != '0 && i_num_frames != '0) begin
            w_len_nxt    = i_frame_len;
            w_num_nxt    = i_num_frames;
            w_gap_nxt    = i_gap_cycles;
            w_tdata_nxt  = i_start_value;
            w_tvalid_nxt = 1'b1;
            w_tlast_nxt  = (i_frame_len == LW'(1));
            w_beat_nxt   = '0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_SEND;
          end else begin
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_FINISH;
          end
        end
      end

      S_SEND: begin
        w_stop_nxt = r_stop | i_stop;
        if (w_accept) begin
          w_tdata_nxt = r_tdata + DW'(1);
          if (r_tlast) begin
            w_frames_nxt = r_frames + 16'd1;
            w_beat_nxt   = '0;
            if (w_frames_nxt == r_num || w_stop_nxt) begin
              w_tvalid_nxt = 1'b0;
              w_tlast_nxt  = 1'b0;
              w_busy_nxt   = 1'b0;
              w_done_nxt   = 1'b1;
              w_state_nxt  = S_FINISH;
            end else if (r_gap != '0) begin
              w_tvalid_nxt  = 1'b0;
              w_tlast_nxt   = 1'b0;
              // the edge entering GAP is the first of the gap_cycles low cycles
              w_gap_cnt_nxt = r_gap - GW'(1);
              w_state_nxt   = S_GAP;
            end else begin
              w_tlast_nxt = (r_len == LW'(1));
            end
          end else begin
            w_beat_nxt  = r_beat + LW'(1);
            w_tlast_nxt = ((r_beat + LW'(1)) == w_len_m1);
          end
        end
      end

      S_GAP: begin
        if (r_stop | i_stop) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_FINISH;
        end else if (r_gap_cnt == '0) begin
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = (r_len == LW'(1));
          w_state_nxt  = S_SEND;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GW'(1);
        end
      end

      S_FINISH: begin
        w_stop_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_num     <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_beat    <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_frames  <= '0;
      r_stop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_num     <= w_num_nxt;
      r_gap     <= w_gap_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_beat    <= w_beat_nxt;
      r_tdata   <= w_tdata_nxt;
      r_tvalid  <= w_tvalid_nxt;
      r_tlast   <= w_tlast_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_frames  <= w_frames_nxt;
      r_stop    <= w_stop_nxt;
    end
  end

  assign m00_axis.tvalid = r_tvalid;
  assign m00_axis.tdata  = r_tdata;
  assign m00_axis.tlast  = r_tlast;
  assign m00_axis.tstrb  = '1;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_frames_sent   = r_frames;

endmodule

// File: tb/tb_axis_frame_gen.sv
module tb_axis_frame_gen;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int GW = 8;

  logic          aclk;
  logic          areset;
  logic          start;
  logic          stop;
  logic [LW-1:0] frame_len;
  logic [15:0]   num_frames;
  logic [GW-1:0] gap_cycles;
  logic [DW-1:0] start_value;
  logic          busy;
  logic          done;
  logic [15:0]   frames_sent;

  axis_frame_gen_if #(.DATA_WIDTH(DW)) m_axis ();

  axis_frame_gen #(
    .C_M00_AXIS_TDATA_WIDTH(DW),
    .FRAME_LEN_WIDTH(LW),
    .GAP_WIDTH(GW)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .i_start(start),
    .i_stop(stop),
    .i_frame_len(frame_len),
    .i_num_frames(num_frames),
    .i_gap_cycles(gap_cycles),
    .i_start_value(start_value),
    .o_busy(busy),
    .o_done(done),
    .o_frames_sent(frames_sent),
    .m00_axis(m_axis)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int            len;
    int            num;
    int            gap;
    logic [DW-1:0] sv;
    int            rmode;       // 0: ready=1, 1: random, 2: ready=0
    int            stop_beat;   // pulse stop once this many beats accepted; -1 none
    int            exp_frames;
  } vec_t;

  beat_t exp_q[$];
  int    gap_seen[$];
  vec_t  vecs[8];

  int checks;
  int failures;
  int cyc;
  int acc_cnt;
  int last_acc_cyc;
  int tready_mode;

  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic          after_tlast;
  int            low_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge aclk);
      cyc++;
    end
  end

  initial begin
    m_axis.tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (tready_mode)
        0:       m_axis.tready = 1'b1;
        1:       m_axis.tready = 1'($urandom_range(0, 1));
        default: m_axis.tready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop on every accepted beat, stall stability, gap lengths.
  initial begin
    beat_t e;
    prev_stall  = 1'b0;
    prev_data   = '0;
    prev_last   = 1'b0;
    after_tlast = 1'b0;
    low_cnt     = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall  = 1'b0;
        after_tlast = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_tvalid", 64'(m_axis.tvalid), 64'(1));
          chk("stall_tdata", 64'(m_axis.tdata), 64'(prev_data));
          chk("stall_tlast", 64'(m_axis.tlast), 64'(prev_last));
        end
        if (after_tlast) begin
          if (m_axis.tvalid) begin
            gap_seen.push_back(low_cnt);
            after_tlast = 1'b0;
          end else if (busy) begin
            low_cnt++;
          end else begin
            after_tlast = 1'b0;
          end
        end
        if (m_axis.tvalid && m_axis.tready) begin
          acc_cnt++;
          last_acc_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual_tdata=0x%0h expected=none", m_axis.tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_tdata", 64'(m_axis.tdata), 64'(e.data));
            chk("beat_tlast", 64'(m_axis.tlast), 64'(e.last));
          end
          if (m_axis.tlast) begin
            after_tlast = 1'b1;
            low_cnt     = 0;
          end
        end
        prev_stall = m_axis.tvalid && !m_axis.tready;
        prev_data  = m_axis.tdata;
        prev_last  = m_axis.tlast;
      end
    end
  end

  task automatic run_case(input vec_t v);
    beat_t e;
    int    n_beats;
    int    wait_c;
    int    done_cyc;
    int    bad;
    bit    got_done;
    bit    stop_sent;
    exp_q.delete();
    gap_seen.delete();
    acc_cnt      = 0;
    last_acc_cyc = -100;
    tready_mode  = v.rmode;
    @(posedge aclk); #1;
    frame_len   = LW'(v.len);
    num_frames  = 16'(v.num);
    gap_cycles  = GW'(v.gap);
    start_value = v.sv;
    start       = 1'b1;
    n_beats = v.exp_frames * v.len;
    for (int k = 0; k < n_beats; k++) begin
      e.data = v.sv + DW'(k);
      e.last = ((k % v.len) == (v.len - 1));
      exp_q.push_back(e);
    end
    @(posedge aclk); #1;
    start = 1'b0;
    if (n_beats > 0) begin
      chk("start_tvalid", 64'(m_axis.tvalid), 64'(1));
      chk("start_tdata", 64'(m_axis.tdata), 64'(v.sv));
      chk("start_busy", 64'(busy), 64'(1));
    end
    got_done  = 1'b0;
    stop_sent = 1'b0;
    done_cyc  = 0;
    wait_c    = 0;
    for (int c = 0; c < 3000; c++) begin
      wait_c = c;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (v.stop_beat >= 0 && !stop_sent && acc_cnt >= v.stop_beat) begin
        stop      = 1'b1;
        stop_sent = 1'b1;
      end else begin
        stop = 1'b0;
      end
      @(posedge aclk); #1;
    end
    stop = 1'b0;
    chk("done_seen", 64'(got_done), 64'(1));
    if (got_done) begin
      chk("frames_sent", 64'(frames_sent), 64'(v.exp_frames));
      chk("done_busy", 64'(busy), 64'(0));
      chk("done_tvalid", 64'(m_axis.tvalid), 64'(0));
      if (n_beats > 0)
        chk("done_latency", 64'(done_cyc - last_acc_cyc), 64'(1));
      else
        chk("zero_done_latency", 64'(wait_c), 64'(0));
    end
    @(posedge aclk); #1;
    chk("done_pulse_end", 64'(done), 64'(0));
    chk("frames_hold", 64'(frames_sent), 64'(v.exp_frames));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    if (v.exp_frames == v.num && v.num > 1) begin
      chk("gap_count", 64'(gap_seen.size()), 64'(v.num - 1));
      bad = 0;
      foreach (gap_seen[i]) if (gap_seen[i] != v.gap) bad++;
      chk("gap_len_bad", 64'(bad), 64'(0));
    end
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{len: 4,  num: 1, gap: 0, sv: 32'h0000_0010, rmode: 0, stop_beat: -1, exp_frames: 1};
    vecs[1] = '{len: 20, num: 1, gap: 0, sv: 32'h0000_0001, rmode: 1, stop_beat: -1, exp_frames: 1};
    vecs[2] = '{len: 3,  num: 3, gap: 2, sv: 32'h0000_0000, rmode: 0, stop_beat: -1, exp_frames: 3};
    vecs[3] = '{len: 1,  num: 4, gap: 0, sv: 32'hFFFF_FFFE, rmode: 0, stop_beat: -1, exp_frames: 4};
    vecs[4] = '{len: 4,  num: 5, gap: 0, sv: 32'h0000_0100, rmode: 0, stop_beat: 5,  exp_frames: 2};
    vecs[5] = '{len: 4,  num: 0, gap: 0, sv: 32'h0000_0000, rmode: 0, stop_beat: -1, exp_frames: 0};
    vecs[6] = '{len: 0,  num: 2, gap: 1, sv: 32'h0000_0000, rmode: 0, stop_beat: -1, exp_frames: 0};
    vecs[7] = '{len: 5,  num: 3, gap: 1, sv: 32'hABCD_0000, rmode: 1, stop_beat: -1, exp_frames: 3};

    checks      = 0;
    failures    = 0;
    tready_mode = 0;
    areset      = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    frame_len   = '0;
    num_frames  = '0;
    gap_cycles  = '0;
    start_value = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'(0));
    chk("rst_tdata", 64'(m_axis.tdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_frames", 64'(frames_sent), 64'(0));
    chk("rst_tstrb", 64'(m_axis.tstrb), 64'(4'hF));
    areset = 1'b0;

    for (int i = 0; i < 8; i++) run_case(vecs[i]);

    // Reset in the middle of a stalled frame.
    tready_mode = 0;
    exp_q.delete();
    @(posedge aclk); #1;
    frame_len   = 16'd2;
    num_frames  = 16'd3;
    gap_cycles  = 8'd0;
    start_value = 32'h0000_0500;
    start       = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back('{data: 32'h500 + DW'(k), last: (k % 2) == 1});
    @(posedge aclk); #1;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (frames_sent >= 16'd1) break;
      @(posedge aclk); #1;
    end
    tready_mode = 2;
    repeat (3) begin
      @(posedge aclk); #1;
    end
    chk("pre_rst_frames", 64'(frames_sent), 64'(1));
    chk("pre_rst_stall", 64'(m_axis.tvalid && !m_axis.tready), 64'(1));
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("mid_rst_tvalid", 64'(m_axis.tvalid), 64'(0));
    chk("mid_rst_tlast", 64'(m_axis.tlast), 64'(0));
    chk("mid_rst_tdata", 64'(m_axis.tdata), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_frames", 64'(frames_sent), 64'(0));
    chk("mid_rst_tstrb", 64'(m_axis.tstrb), 64'(4'hF));
    areset = 1'b0;
    exp_q.delete();

    run_case(vecs[5]);
    run_case(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
